// File: rtl/stack_mem_sequencer.sv
// -----------------------------------------------------------------------------
// stack_mem_sequencer
//
// Performs the memory half of PUSH, POP, CALL and RET. The block takes the
// current SP and an operand (Rs or NPC), runs one data-memory transaction over
// a req/ack handshake, and returns the updated SP and the popped word (LMD).
// It also checks the stack bounds and aborts the transaction on a timeout.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, stack_op   one-cycle request and opcode (001 PUSH, 010 POP,
//                     011 CALL, 100 RET); start is sampled only in IDLE
//   sp_in, wdata_in   current SP and the word to write (Rs or NPC)
//   busy, done        busy outside IDLE; done pulses once at completion
//   sp_out, lmd_out   updated SP and the popped word, held between operations
//   err_overflow      pulses with done when PUSH/CALL finds the stack full
//   err_underflow     pulses with done when POP/RET finds the stack empty
//   err_timeout       pulses with done when mem_ack does not arrive in time
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                     data-memory handshake; all memory addresses are word
//                     addresses
// -----------------------------------------------------------------------------
module stack_mem_sequencer #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_03FF,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0300,
  parameter int          TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  stack_op,
  input  logic [31:0] sp_in,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] sp_out,
  output logic [31:0] lmd_out,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MEM, S_FIN} state_t;

  state_t        state_q;
  logic          is_write_q;
  logic [31:0]   sp_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;

  logic          busy_q, done_q;
  logic          err_ov_q, err_un_q, err_to_q;
  logic [31:0]   sp_out_q, lmd_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;

  logic        op_valid;
  logic        op_write;
  logic [31:0] sp_dec;
  logic [31:0] sp_inc;

  assign op_valid = stack_op inside {OP_PUSH, OP_POP, OP_CALL, OP_RET};
  assign op_write = (stack_op == OP_PUSH) || (stack_op == OP_CALL);
  // SP arithmetic wraps modulo 2^32.
  assign sp_dec   = sp_q - 32'd1;
  assign sp_inc   = sp_q + 32'd1;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including the datapath
    // latches, is cleared so no X can reach the memory port after reset.
    if (rst) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      sp_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ov_q    <= 1'b0;
      err_un_q    <= 1'b0;
      err_to_q    <= 1'b0;
      sp_out_q    <= STACK_BASE + 32'd1;
      lmd_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. The pulse defaults below
      // are overridden by any later assignment in the same cycle.
      done_q   <= 1'b0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
      err_to_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start && op_valid) begin
            is_write_q <= op_write;
            sp_q       <= sp_in;
            wdata_q    <= wdata_in;
            busy_q     <= 1'b1;
            state_q    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (is_write_q && (sp_q <= STACK_LIMIT)) begin
            err_ov_q <= 1'b1;
            done_q   <= 1'b1;
            sp_out_q <= sp_q;
            state_q  <= S_FIN;
          end else if (!is_write_q && (sp_q > STACK_BASE)) begin
            err_un_q <= 1'b1;
            done_q   <= 1'b1;
            sp_out_q <= sp_q;
            state_q  <= S_FIN;
          end else begin
            // A write goes to the slot just below SP. A read takes the slot
            // at SP.
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_write_q;
            mem_addr_q  <= is_write_q ? sp_dec : sp_q;
            mem_wdata_q <= is_write_q ? wdata_q : 32'd0;
            state_q     <= S_MEM;
          end
        end

        S_MEM: begin
          if (mem_ack || (cnt_q == CNT_LAST)) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            state_q     <= S_FIN;
            if (!mem_ack) begin
              err_to_q <= 1'b1;
              sp_out_q <= sp_q;
            end else if (is_write_q) begin
              sp_out_q <= sp_dec;
            end else begin
              sp_out_q <= sp_inc;
              lmd_q    <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign sp_out        = sp_out_q;
  assign lmd_out       = lmd_q;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
  assign err_timeout   = err_to_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_stack_mem_sequencer.sv
module tb_stack_mem_sequencer;

  localparam logic [31:0] BASE    = 32'h0000_03FF;
  localparam logic [31:0] LIMIT   = 32'h0000_0300;
  localparam int          TIMEOUT = 15;
  localparam int          NEVER   = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  stack_op = '0;
  logic [31:0] sp_in = '0, wdata_in = '0;
  logic        busy, done;
  logic [31:0] sp_out, lmd_out;
  logic        err_overflow, err_underflow, err_timeout;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  stack_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stack_op(stack_op),
    .sp_in(sp_in), .wdata_in(wdata_in), .busy(busy), .done(done),
    .sp_out(sp_out), .lmd_out(lmd_out), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Result of one operation: latency from the start cycle to done, the number
  // of mem_req cycles, the memory command, and the outputs seen at done.
  typedef struct {
    int          lat;
    int          req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    bit          stable;
    logic [31:0] sp;
    logic [31:0] lmd;
    logic        ov, un, to;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] sp, wd;
    int          delay;
    logic [31:0] rdata;
    res_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_arr [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome worked out directly from the stack rules. A delay of d
  // means the ack arrives in mem_req cycle d+1.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] sp,
                                 input logic [31:0] wd, input int delay,
                                 input logic [31:0] rdata, input logic [31:0] old_lmd);
    res_t r;
    bit   wr;
    wr = (op == 3'd1) || (op == 3'd3);
    r = '{lat: 0, req: 0, addr: 0, we: 0, wdata: 0, stable: 1,
          sp: sp, lmd: old_lmd, ov: 0, un: 0, to: 0};
    if (wr && sp <= LIMIT) begin
      r.ov = 1; r.lat = 2;
    end else if (!wr && sp > BASE) begin
      r.un = 1; r.lat = 2;
    end else begin
      r.we    = wr;
      r.addr  = wr ? sp - 32'd1 : sp;
      r.wdata = wr ? wd : 32'd0;
      if (delay >= TIMEOUT) begin
        r.to = 1; r.req = TIMEOUT; r.lat = TIMEOUT + 2;
      end else begin
        r.req = delay + 1;
        r.lat = delay + 3;
        if (wr) r.sp = sp - 32'd1;
        else begin
          r.sp  = sp + 32'd1;
          r.lmd = rdata;
        end
      end
    end
    return r;
  endfunction

  // Run one operation and act as the memory. While the DUT is busy the task
  // also pulses start at random with random inputs. These pulses must be
  // ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] sp, input logic [31:0] wd,
                        input int delay, input logic [31:0] rdata, input bit use_mem,
                        output res_t o);
    o = '{lat: 0, req: 0, addr: 0, we: 0, wdata: 0, stable: 1,
          sp: 0, lmd: 0, ov: 0, un: 0, to: 0};
    stack_op = op; sp_in = sp; wdata_in = wd; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        o.req++;
        if (o.req == 1) begin
          o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata) begin
          o.stable = 0;
        end
        if (o.req == delay + 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else if (use_mem) mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'hBAD0_0000;
          else mem_rdata = rdata;
        end
      end
      if (done) begin
        o.lat = cyc; o.sp = sp_out; o.lmd = lmd_out;
        o.ov = err_overflow; o.un = err_underflow; o.to = err_timeout;
        break;
      end
      stack_op = 3'($urandom); sp_in = $urandom; wdata_in = $urandom;
      start = busy && ($urandom_range(0, 1) == 1);
      step();
      start = 1'b0;
    end
    mem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t o, input res_t e);
    check({tag, " latency"}, o.lat, e.lat);
    check({tag, " req_cycles"}, o.req, e.req);
    if (e.req > 0) begin
      check({tag, " addr"}, o.addr, e.addr);
      check({tag, " we"}, o.we, e.we);
      check({tag, " wdata"}, o.wdata, e.wdata);
      check({tag, " cmd_stable"}, o.stable, 1);
    end
    check({tag, " sp_out"}, o.sp, e.sp);
    check({tag, " lmd_out"}, o.lmd, e.lmd);
    check({tag, " err_ov"}, o.ov, e.ov);
    check({tag, " err_un"}, o.un, e.un);
    check({tag, " err_to"}, o.to, e.to);
    step();
    check({tag, " idle_after"}, {busy, done}, 2'b00);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] sp, input logic [31:0] wd,
                              input int delay, input logic [31:0] rdata,
                              input int lat, input int req, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdat, input logic [31:0] spo,
                              input logic [31:0] lmd, input logic ov, input logic un,
                              input logic to);
    vec_t v;
    v.op = op; v.sp = sp; v.wd = wd; v.delay = delay; v.rdata = rdata;
    v.exp = '{lat: lat, req: req, addr: addr, we: we, wdata: wdat, stable: 1,
              sp: spo, lmd: lmd, ov: ov, un: un, to: to};
    return v;
  endfunction

  initial begin
    vec_t        vecs[10];
    res_t        o, e;
    logic [31:0] model_lmd, model_sp, val;
    logic [31:0] lifo[$];
    bit          seen_done, seen_busy;
    logic [2:0]  bad_ops[4];
    logic [2:0]  rop;
    logic [31:0] rsp;

    //            op    sp            wd            dly    rdata         lat req addr          we wdata         sp_out        lmd           ov un to
    vecs[0] = mk(3'd1, 32'h400,      32'hDEADBEEF, 0,     32'h0,        3,  1,  32'h3FF,      1, 32'hDEADBEEF, 32'h3FF,      32'h0,        0, 0, 0);
    vecs[1] = mk(3'd2, 32'h3FF,      32'h0,        4,     32'h1234,     7,  5,  32'h3FF,      0, 32'h0,        32'h400,      32'h1234,     0, 0, 0);
    vecs[2] = mk(3'd3, 32'h300,      32'h11,       0,     32'h0,        2,  0,  32'h0,        0, 32'h0,        32'h300,      32'h1234,     1, 0, 0);
    vecs[3] = mk(3'd1, 32'h301,      32'h55,       1,     32'h0,        4,  2,  32'h300,      1, 32'h55,       32'h300,      32'h1234,     0, 0, 0);
    vecs[4] = mk(3'd4, 32'h400,      32'h0,        0,     32'h0,        2,  0,  32'h0,        0, 32'h0,        32'h400,      32'h1234,     0, 1, 0);
    vecs[5] = mk(3'd4, 32'h3FF,      32'h0,        2,     32'hCAFE,     5,  3,  32'h3FF,      0, 32'h0,        32'h400,      32'hCAFE,     0, 0, 0);
    vecs[6] = mk(3'd1, 32'h3FF,      32'h77,       NEVER, 32'h0,        17, 15, 32'h3FE,      1, 32'h77,       32'h3FF,      32'hCAFE,     0, 0, 1);
    vecs[7] = mk(3'd2, 32'h0,        32'h0,        0,     32'h7,        3,  1,  32'h0,        0, 32'h0,        32'h1,        32'h7,        0, 0, 0);
    vecs[8] = mk(3'd3, 32'hFFFFFFFF, 32'hA5A5,     14,    32'h0,        17, 15, 32'hFFFFFFFE, 1, 32'hA5A5,     32'hFFFFFFFE, 32'h7,        0, 0, 0);
    vecs[9] = mk(3'd2, 32'h3FF,      32'h0,        15,    32'h99,       17, 15, 32'h3FF,      0, 32'h0,        32'h3FF,      32'h7,        0, 0, 1);

    // Reset values.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset sp_out", sp_out, 32'h400);
    check("reset lmd_out", lmd_out, 32'h0);
    check("reset busy/done", {busy, done}, 2'b00);
    check("reset err", {err_overflow, err_underflow, err_timeout}, 3'b000);
    check("reset mem", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].sp, vecs[i].wd, vecs[i].delay, vecs[i].rdata, 1'b0, o);
      compare($sformatf("vec%0d", i), o, vecs[i].exp);
    end

    // An invalid opcode with start, or no start at all, must leave the DUT
    // idle.
    bad_ops = '{3'b000, 3'b101, 3'b110, 3'b111};
    foreach (bad_ops[k]) begin
      stack_op = bad_ops[k]; start = 1'b1;
      step();
      start = 1'b0;
      seen_done = 0; seen_busy = 0;
      for (int c = 0; c < 4; c++) begin
        seen_done |= done; seen_busy |= busy;
        step();
      end
      check($sformatf("invalid op %b no done", bad_ops[k]), seen_done, 0);
      check($sformatf("invalid op %b not busy", bad_ops[k]), seen_busy, 0);
    end

    // Random operations checked against the rule model.
    model_lmd = 32'h7;
    for (int n = 0; n < 40; n++) begin
      int dly;
      rop = 3'($urandom_range(1, 4));
      case ($urandom_range(0, 5))
        0: rsp = LIMIT;
        1: rsp = LIMIT + 32'd1;
        2: rsp = BASE;
        3: rsp = BASE + 32'd1;
        4: rsp = $urandom_range(32'h300, 32'h400);
        default: rsp = $urandom;
      endcase
      dly = $urandom_range(0, 16);
      val = $urandom;
      e = model(rop, rsp, val, dly, ~val, model_lmd);
      run_op(rop, rsp, val, dly, ~val, 1'b0, o);
      compare($sformatf("rand%0d", n), o, e);
      model_lmd = e.lmd;
    end

    // LIFO round trip through the bench memory. Pops return the pushed
    // words in reverse order.
    model_sp = BASE + 32'd1;
    for (int n = 0; n < 5; n++) begin
      val = $urandom;
      e = model(3'd1, model_sp, val, $urandom_range(0, 3), 32'h0, model_lmd);
      run_op(3'd1, model_sp, val, e.req - 1, 32'h0, 1'b1, o);
      compare($sformatf("lifo_push%0d", n), o, e);
      lifo.push_back(val);
      model_sp = model_sp - 32'd1;
    end
    for (int n = 0; n < 5; n++) begin
      val = lifo.pop_back();
      e = model(3'd2, model_sp, 32'h0, $urandom_range(0, 3), val, model_lmd);
      run_op(3'd2, model_sp, 32'h0, e.req - 1, 32'h0, 1'b1, o);
      compare($sformatf("lifo_pop%0d", n), o, e);
      model_lmd = val;
      model_sp = model_sp + 32'd1;
    end

    // Reset during the second MEM cycle.
    stack_op = 3'd1; sp_in = 32'h350; wdata_in = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rst_mid mem1 req", mem_req, 1);
    step();
    check("rst_mid mem2 req", mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid mem_req", mem_req, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid sp_out", sp_out, 32'h400);
    check("rst_mid lmd_out", lmd_out, 32'h0);
    check("rst_mid done", done, 0);

    // A normal operation works after the mid-transaction reset.
    e = model(3'd1, 32'h3A0, 32'h4242, 2, 32'h0, 32'h0);
    run_op(3'd1, 32'h3A0, 32'h4242, 2, 32'h0, 1'b0, o);
    compare("post_rst push", o, e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
